// File: rtl/rx_frame_ctrl_pkg.sv
// Shared types and constants for the receive-side frame sequencer.
package rx_frame_ctrl_pkg;

  // One-hot sequencer states.
  typedef enum logic [5:0] {
    StIdle     = 6'b000001,
    StHdr      = 6'b000010,
    StBody     = 6'b000100,
    StCrc      = 6'b001000,
    StDrop     = 6'b010000,
    StDoneWait = 6'b100000
  } rx_state_e;

  localparam logic [7:0] CdBroadcast = 8'hff;
  localparam logic [8:0] CdHdrLen    = 9'd3;
  localparam logic [8:0] CdCrcLen    = 9'd2;

  // Byte index of the final CRC byte for a given payload length.
  function automatic logic [8:0] crc_last_idx(input logic [7:0] len);
    return CdHdrLen + {1'b0, len} + CdCrcLen - 9'd1;
  endfunction

endpackage

// File: rtl/rx_frame_ctrl_if.sv
// Deserializer byte stream plus rx buffer write port.
interface rx_frame_ctrl_if #(
  parameter int unsigned BUF_AW = 8
) ();

  logic [7:0]        data;
  logic              data_clk;
  logic [15:0]       crc_data;
  logic              bus_idle;
  logic              force_wait_idle;
  logic              wr_en;
  logic [BUF_AW-1:0] wr_addr;
  logic [7:0]        wr_data;

  // Deserializer / buffer side.
  modport master (
    output data, data_clk, crc_data, bus_idle,
    input  force_wait_idle, wr_en, wr_addr, wr_data
  );

  // Frame controller side.
  modport slave (
    input  data, data_clk, crc_data, bus_idle,
    output force_wait_idle, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/rx_frame_ctrl_sat_cnt8.sv
// 8-bit saturating event counter; clear beats a simultaneous increment.
module rx_frame_ctrl_sat_cnt8 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       inc_i,
  input  logic       clr_i,
  output logic [7:0] cnt_o
);

  logic [7:0] cnt_q, cnt_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 8'h00;
    end else if (inc_i && (cnt_q != 8'hff)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 8'h00;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/rx_frame_ctrl.sv
// Receive frame sequencer: header parse, address filter, buffer write, CRC residue check.
module rx_frame_ctrl
  import rx_frame_ctrl_pkg::*;
#(
  parameter int unsigned BUF_AW  = 8,
  parameter int unsigned MAX_LEN = 253
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [7:0]     filter,
  input  logic           promisc,
  input  logic           buf_free,
  input  logic           abort,
  input  logic           cnt_clr,
  rx_frame_ctrl_if.slave bus,
  output logic           rx_done,
  output logic [7:0]     rx_len,
  output logic           crc_err,
  output logic           brk_err,
  output logic [7:0]     cnt_crc_err,
  output logic [7:0]     cnt_lost
);

  localparam logic [8:0] MaxLen = 9'(MAX_LEN);

  rx_state_e         state_q, state_d;
  logic [8:0]        byte_cnt_q, byte_cnt_d;
  logic [7:0]        len_q, len_d;
  logic              wr_en_q, wr_en_d;
  logic [BUF_AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              fwi_q, fwi_d;
  logic              rx_done_q, rx_done_d;
  logic [7:0]        rx_len_q, rx_len_d;
  logic              crc_err_q, crc_err_d;
  logic              brk_err_q, brk_err_d;
  logic              lost_inc, crc_inc;

  logic dst_miss, len_bad, body_last, crc_last;

  assign dst_miss  = (bus.data != filter) && (bus.data != CdBroadcast) && !promisc;
  assign len_bad   = {1'b0, bus.data} > MaxLen;
  assign body_last = byte_cnt_q == (CdHdrLen + {1'b0, len_q} - 9'd1);
  assign crc_last  = byte_cnt_q == crc_last_idx(len_q);

  // Next-state and registered-output logic; priority abort > data_clk > bus_idle.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    fwi_d      = 1'b0;
    rx_done_d  = 1'b0;
    rx_len_d   = rx_len_q;
    crc_err_d  = 1'b0;
    brk_err_d  = 1'b0;
    lost_inc   = 1'b0;
    crc_inc    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.data_clk) begin
          if (buf_free) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = '0;
            wr_data_d  = bus.data;
            byte_cnt_d = 9'd1;
            state_d    = StHdr;
          end else begin
            lost_inc = 1'b1;
            fwi_d    = 1'b1;
            state_d  = StDrop;
          end
        end
      end

      StHdr, StBody, StCrc: begin
        if (abort) begin
          fwi_d   = 1'b1;
          state_d = StDrop;
        end else if (bus.data_clk) begin
          byte_cnt_d = byte_cnt_q + 9'd1;
          // CRC bytes are checked via the residue only, never stored.
          if (state_q != StCrc) begin
            wr_en_d   = 1'b1;
            wr_addr_d = byte_cnt_q[BUF_AW-1:0];
            wr_data_d = bus.data;
          end
          if (state_q == StHdr) begin
            if (byte_cnt_q == 9'd1) begin
              if (dst_miss) begin
                fwi_d   = 1'b1;
                state_d = StDrop;
              end
            end else if (len_bad) begin
              lost_inc = 1'b1;
              fwi_d    = 1'b1;
              state_d  = StDrop;
            end else begin
              len_d   = bus.data;
              state_d = (bus.data == 8'd0) ? StCrc : StBody;
            end
          end else if (state_q == StBody) begin
            if (body_last) begin
              state_d = StCrc;
            end
          end else if (crc_last) begin
            if (bus.crc_data == 16'h0000) begin
              rx_done_d = 1'b1;
              rx_len_d  = len_q;
            end else begin
              crc_err_d = 1'b1;
              crc_inc   = 1'b1;
            end
            state_d = StDoneWait;
          end
        end else if (bus.bus_idle) begin
          brk_err_d = 1'b1;
          state_d   = StIdle;
        end
      end

      StDrop, StDoneWait: begin
        if (bus.bus_idle) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      byte_cnt_q <= '0;
      len_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      fwi_q      <= 1'b0;
      rx_done_q  <= 1'b0;
      rx_len_q   <= '0;
      crc_err_q  <= 1'b0;
      brk_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      fwi_q      <= fwi_d;
      rx_done_q  <= rx_done_d;
      rx_len_q   <= rx_len_d;
      crc_err_q  <= crc_err_d;
      brk_err_q  <= brk_err_d;
    end
  end

  rx_frame_ctrl_sat_cnt8 u_cnt_crc_err (
    .clk     (clk),
    .reset_n (reset_n),
    .inc_i   (crc_inc),
    .clr_i   (cnt_clr),
    .cnt_o   (cnt_crc_err)
  );

  rx_frame_ctrl_sat_cnt8 u_cnt_lost (
    .clk     (clk),
    .reset_n (reset_n),
    .inc_i   (lost_inc),
    .clr_i   (cnt_clr),
    .cnt_o   (cnt_lost)
  );

  assign bus.wr_en           = wr_en_q;
  assign bus.wr_addr         = wr_addr_q;
  assign bus.wr_data         = wr_data_q;
  assign bus.force_wait_idle = fwi_q;
  assign rx_done             = rx_done_q;
  assign rx_len              = rx_len_q;
  assign crc_err             = crc_err_q;
  assign brk_err             = brk_err_q;

endmodule
